// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences the shared multiply/divide engines for the multicycle
// CPU and owns the architectural HI/LO registers.
// Optional WAIT-state watchdog with extra `timeout` port: define MULDIV_TIMEOUT_EN.
module muldiv_ctrl #(
    parameter int WIDTH = 32
`ifdef MULDIV_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 64
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    input  logic [1:0]       op_code,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
`ifdef MULDIV_TIMEOUT_EN
    output logic             timeout,
`endif
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             mul_start,
    output logic [WIDTH-1:0] mul_a,
    output logic [WIDTH-1:0] mul_b,
    input  logic [WIDTH-1:0] mul_hi,
    input  logic [WIDTH-1:0] mul_lo,
    input  logic             mul_ready,
    output logic             div_start,
    output logic [WIDTH-1:0] div_a,
    output logic [WIDTH-1:0] div_b,
    input  logic [WIDTH-1:0] div_q,
    input  logic [WIDTH-1:0] div_r,
    input  logic             div_ready
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2} state_t;
    typedef enum logic {SEL_MUL = 1'b0, SEL_DIV = 1'b1} sel_t;
    typedef enum logic [1:0] {OP_MULT = 2'b00, OP_DIV = 2'b01, OP_MTHI = 2'b10, OP_MTLO = 2'b11} op_t;

    state_t           r_state;
    state_t           w_next_state;
    sel_t             r_sel;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;
    logic             r_div_zero;

    logic             w_latch;
    logic             w_wr_hi;
    logic             w_wr_lo;
    logic [WIDTH-1:0] w_hi_d;
    logic [WIDTH-1:0] w_lo_d;
    logic             w_done;
    logic             w_div_zero;
    logic             w_sel_ready;

`ifdef MULDIV_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;
    logic             w_timeout;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state decode plus HI/LO write and completion strobes; the commit
    // happens on the WAIT exit edge, so there is no separate COMMIT state
    always_comb begin
        w_next_state = r_state;
        w_latch      = 1'b0;
        w_wr_hi      = 1'b0;
        w_wr_lo      = 1'b0;
        w_hi_d       = '0;
        w_lo_d       = '0;
        w_done       = 1'b0;
        w_div_zero   = 1'b0;
        w_sel_ready  = (r_sel == SEL_MUL) ? mul_ready : div_ready;
`ifdef MULDIV_TIMEOUT_EN
        w_timeout    = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (op_valid) begin
                    case (op_code)
                        OP_MULT: begin
                            w_latch      = 1'b1;
                            w_next_state = S_ISSUE;
                        end
                        OP_DIV: begin
                            if (rt_val == '0) begin
                                w_done     = 1'b1;
                                w_div_zero = 1'b1;
                            end else begin
                                w_latch      = 1'b1;
                                w_next_state = S_ISSUE;
                            end
                        end
                        OP_MTHI: begin
                            w_wr_hi = 1'b1;
                            w_hi_d  = rs_val;
                            w_done  = 1'b1;
                        end
                        OP_MTLO: begin
                            w_wr_lo = 1'b1;
                            w_lo_d  = rs_val;
                            w_done  = 1'b1;
                        end
                    endcase
                end
            end
            S_ISSUE: w_next_state = S_WAIT;
            S_WAIT: begin
                if (w_sel_ready) begin
                    w_next_state = S_IDLE;
                    w_done       = 1'b1;
                    w_wr_hi      = 1'b1;
                    w_wr_lo      = 1'b1;
                    w_hi_d       = (r_sel == SEL_MUL) ? mul_hi : div_r;
                    w_lo_d       = (r_sel == SEL_MUL) ? mul_lo : div_q;
                end
`ifdef MULDIV_TIMEOUT_EN
                else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_next_state = S_IDLE;
                    w_done       = 1'b1;
                    w_timeout    = 1'b1;
                end
`endif
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Operand latch, engine select, HI/LO and one-cycle status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel      <= SEL_MUL;
            r_a        <= '0;
            r_b        <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done     <= w_done;
            r_div_zero <= w_div_zero;
            if (w_latch) begin
                r_sel <= (op_code == OP_DIV) ? SEL_DIV : SEL_MUL;
                r_a   <= rs_val;
                r_b   <= rt_val;
            end
            if (w_wr_hi) r_hi <= w_hi_d;
            if (w_wr_lo) r_lo <= w_lo_d;
        end
    end

`ifdef MULDIV_TIMEOUT_EN
    // Watchdog: cleared while issuing, counts every cycle spent in WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_timeout;
            if (r_state == S_ISSUE)     r_cnt <= '0;
            else if (r_state == S_WAIT) r_cnt <= r_cnt + 1'b1;
        end
    end

    assign timeout = r_timeout;
`endif

    assign busy      = (r_state == S_ISSUE) || (r_state == S_WAIT);
    assign done      = r_done;
    assign div_zero  = r_div_zero;
    assign hi_out    = r_hi;
    assign lo_out    = r_lo;
    assign mul_start = (r_state == S_ISSUE) && (r_sel == SEL_MUL);
    assign div_start = (r_state == S_ISSUE) && (r_sel == SEL_DIV);
    assign mul_a     = r_a;
    assign mul_b     = r_b;
    assign div_a     = r_a;
    assign div_b     = r_b;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl with behavioural multiplier/divider stubs.
module tb_muldiv_ctrl;

    localparam int MUL_LAT = 33;   // start-sample edge to ready edge, 32-iteration multiplier
    localparam int TO_CYC  = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0;
    logic [1:0]  op_code = 2'b00;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        busy, done, div_zero;
    logic [31:0] hi_out, lo_out;
    logic        mul_start, div_start;
    logic [31:0] mul_a, mul_b, div_a, div_b;
    logic [31:0] mul_hi = '0, mul_lo = '0, div_q = '0, div_r = '0;
    logic        mul_ready, div_ready;
`ifdef MULDIV_TIMEOUT_EN
    logic        timeout;
`endif

    always #5 clk = ~clk;

    muldiv_ctrl #(
        .WIDTH(32)
`ifdef MULDIV_TIMEOUT_EN
        , .TIMEOUT(TO_CYC)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_code(op_code),
        .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .done(done), .div_zero(div_zero),
`ifdef MULDIV_TIMEOUT_EN
        .timeout(timeout),
`endif
        .hi_out(hi_out), .lo_out(lo_out),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_hi(mul_hi), .mul_lo(mul_lo), .mul_ready(mul_ready),
        .div_start(div_start), .div_a(div_a), .div_b(div_b),
        .div_q(div_q), .div_r(div_r), .div_ready(div_ready)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- engine stubs ----------------
    int          m_cnt = 0, d_cnt = 0, div_lat = 5;
    logic        m_rdy = 1'b0, d_rdy = 1'b0;
    logic        stray_mul = 1'b0, stray_div = 1'b0;
    bit          mul_inhibit = 1'b0;
    logic [63:0] m_prod = '0;
    logic [31:0] d_qh = '0, d_rh = '0;

    assign mul_ready = m_rdy | stray_mul;
    assign div_ready = d_rdy | stray_div;

    always @(posedge clk) begin
        m_rdy <= 1'b0;
        if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1 && !mul_inhibit) begin
                m_rdy  <= 1'b1;
                mul_hi <= m_prod[63:32];
                mul_lo <= m_prod[31:0];
            end
        end
        if (mul_start) begin
            m_cnt  <= MUL_LAT;
            m_prod <= $signed({{32{mul_a[31]}}, mul_a}) * $signed({{32{mul_b[31]}}, mul_b});
        end
    end

    always @(posedge clk) begin
        d_rdy <= 1'b0;
        if (d_cnt != 0) begin
            d_cnt <= d_cnt - 1;
            if (d_cnt == 1) begin
                d_rdy <= 1'b1;
                div_q <= d_qh;
                div_r <= d_rh;
            end
        end
        if (div_start) begin
            d_cnt <= div_lat;
            d_qh  <= (div_b == 0) ? 32'hFFFF_FFFF : 32'($signed(div_a) / $signed(div_b));
            d_rh  <= (div_b == 0) ? div_a : 32'($signed(div_a) % $signed(div_b));
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        int          cyc;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        logic        to;
    } exp_t;

    exp_t        sb[$];
    exp_t        me;
    int          n_vec = 0, n_err = 0;
    logic [31:0] model_hi = '0, model_lo = '0;
    logic [31:0] vis_hi = '0, vis_lo = '0;
    int          win_kind = 0, win_acc = 0, win_done = 0;
    logic [31:0] win_a = '0, win_b = '0;
    bit          garbage_en = 1'b1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
        longint sa, sb2;
        sa  = longint'($signed(a));
        sb2 = longint'($signed(b));
        return 64'(sa * sb2);
    endfunction

    // Monitor: busy/start/operand windows every cycle, results whenever done is high
    always @(negedge clk) begin : mon
        logic exp_busy;
        exp_busy = (win_kind != 0) && (cyc >= win_acc) && (cyc < win_done);
        chk("busy", 64'(busy), 64'(exp_busy));
        chk("mul_start", 64'(mul_start), 64'(win_kind == 1 && cyc == win_acc));
        chk("div_start", 64'(div_start), 64'(win_kind == 2 && cyc == win_acc));
        if (exp_busy && win_kind == 1) begin
            chk("mul_a", 64'(mul_a), 64'(win_a));
            chk("mul_b", 64'(mul_b), 64'(win_b));
        end
        if (exp_busy && win_kind == 2) begin
            chk("div_a", 64'(div_a), 64'(win_a));
            chk("div_b", 64'(div_b), 64'(win_b));
        end
        if (done) begin
            if (sb.size() == 0) begin
                chk("done_unexpected", 64'(done), 64'(0));
            end else begin
                me = sb.pop_front();
                chk("done_cycle", 64'(cyc), 64'(me.cyc));
                chk("hi_out", 64'(hi_out), 64'(me.hi));
                chk("lo_out", 64'(lo_out), 64'(me.lo));
                chk("div_zero", 64'(div_zero), 64'(me.dz));
`ifdef MULDIV_TIMEOUT_EN
                chk("timeout", 64'(timeout), 64'(me.to));
`endif
                vis_hi <= me.hi;
                vis_lo <= me.lo;
            end
        end else begin
            chk("div_zero_idle", 64'(div_zero), 64'(0));
            chk("hi_hold", 64'(hi_out), 64'(rst_n ? vis_hi : 32'h0));
            chk("lo_hold", 64'(lo_out), 64'(rst_n ? vis_lo : 32'h0));
`ifdef MULDIV_TIMEOUT_EN
            chk("timeout_idle", 64'(timeout), 64'(0));
`endif
            if (!rst_n) begin
                vis_hi <= '0;
                vis_lo <= '0;
            end
        end
    end

    // Driver: called at a negedge with the DUT idle; returns at the negedge done is seen
    task automatic issue(input logic [1:0] code, input logic [31:0] rs, input logic [31:0] rt,
                         input int lat, input bit stray);
        exp_t e;
        int   acc, off, sa, sb2;
        logic [63:0] p;
        acc  = cyc + 1;
        off  = 0;
        e.dz = 1'b0;
        e.to = 1'b0;
        e.hi = model_hi;
        e.lo = model_lo;
        win_kind = 0;
        case (code)
            2'b00: begin
                win_kind = 1;
                if (mul_inhibit) begin
                    off  = TO_CYC + 1;
                    e.to = 1'b1;
                end else begin
                    off  = MUL_LAT + 2;
                    p    = smul(rs, rt);
                    e.hi = p[63:32];
                    e.lo = p[31:0];
                end
            end
            2'b01: begin
                if (rt == 0) begin
                    e.dz = 1'b1;
                end else begin
                    win_kind = 2;
                    off  = lat + 2;
                    sa   = $signed(rs);
                    sb2  = $signed(rt);
                    e.lo = 32'(sa / sb2);
                    e.hi = 32'(sa % sb2);
                end
            end
            2'b10: e.hi = rs;
            default: e.lo = rs;
        endcase
        e.cyc    = acc + off;
        win_acc  = acc;
        win_done = acc + off;
        win_a    = rs;
        win_b    = rt;
        div_lat  = lat;
        model_hi = e.hi;
        model_lo = e.lo;
        sb.push_back(e);
        op_valid = 1'b1;
        op_code  = code;
        rs_val   = rs;
        rt_val   = rt;
        @(negedge clk);
        while (cyc < acc + off) begin
            op_valid = garbage_en ? 1'($urandom_range(0, 1)) : 1'b0;
            op_code  = 2'($urandom_range(0, 3));
            rs_val   = $urandom;
            rt_val   = $urandom;
            stray_mul = stray && (win_kind == 2) && (cyc == acc + 1);
            stray_div = stray && (win_kind == 1) && (cyc == acc + 1);
            @(negedge clk);
        end
        stray_mul = 1'b0;
        stray_div = 1'b0;
        op_valid  = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [1:0]  c;
        logic [31:0] a, b;
        #1;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_hi", 64'(hi_out), 64'(0));
        chk("rst_lo", 64'(lo_out), 64'(0));
        chk("rst_mul_start", 64'(mul_start), 64'(0));
        chk("rst_div_start", 64'(div_start), 64'(0));
        chk("rst_mul_a", 64'(mul_a), 64'(0));
        chk("rst_div_b", 64'(div_b), 64'(0));
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // directed
        issue(2'b00, 32'd7, 32'd6, 0, 1'b0);
        issue(2'b00, 32'hFFFF_FFFF, 32'd2, 0, 1'b0);
        issue(2'b10, 32'h11, 32'h0, 0, 1'b0);
        issue(2'b11, 32'h22, 32'h0, 0, 1'b0);
        issue(2'b01, 32'd5, 32'd0, 0, 1'b0);
        issue(2'b01, 32'd100, 32'd7, 5, 1'b1);
        issue(2'b01, 32'hFFFF_FF9C, 32'd7, 1, 1'b1);

        // reset in the middle of a multiply: state and HI/LO clear, late ready ignored
        issue(2'b10, 32'hAAAA_0001, 32'h0, 0, 1'b0);
        win_kind = 1;
        win_acc  = cyc + 1;
        win_done = cyc + 1 + MUL_LAT + 2;
        win_a    = 32'd3;
        win_b    = 32'd5;
        op_valid = 1'b1;
        op_code  = 2'b00;
        rs_val   = 32'd3;
        rt_val   = 32'd5;
        @(negedge clk);
        op_valid = 1'b0;
        repeat (10) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_hi", 64'(hi_out), 64'(0));
        chk("midrst_lo", 64'(lo_out), 64'(0));
        win_kind = 0;
        model_hi = '0;
        model_lo = '0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (40) @(negedge clk);

        // randomized
        for (int i = 0; i < 40; i++) begin
            c = 2'($urandom_range(0, 3));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            if (c == 2'b00 && $urandom_range(0, 1) == 1) b = 32'($urandom_range(0, 255));
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
            issue(c, a, b, int'($urandom_range(1, 8)), 1'($urandom_range(0, 1)));
        end

`ifdef MULDIV_TIMEOUT_EN
        issue(2'b10, 32'h0000_0123, 32'h0, 0, 1'b0);
        mul_inhibit = 1'b1;
        issue(2'b00, 32'd5, 32'd9, 0, 1'b0);
        repeat (40) @(negedge clk);
        mul_inhibit = 1'b0;
`endif

        repeat (3) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Sequences the shared multiply and divide engines for the multicycle CPU.
- Accepts MULT/DIV/MTHI/MTLO commands from the main control unit and issues a one-cycle start to the selected engine.
- Waits for the engine's ready pulse, then commits the result into the architectural HI/LO registers.
- Holds the CPU stalled via busy throughout the operation; MFHI/MFLO read hi_out/lo_out directly.

Parameters:
- WIDTH, 32, operand and HI/LO width; the engines are fixed at 32.
- TIMEOUT, 64, watchdog limit in cycles spent in WAIT; used only with MULDIV_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- op_valid  in  1  command strobe from control unit.
- op_code  in  2  00 MULT, 01 DIV, 10 MTHI, 11 MTLO.
- rs_val  in  WIDTH  first operand / MTHI/MTLO source.
- rt_val  in  WIDTH  second operand (multiplier / divisor).
- busy  out  1  high while an engine operation is in flight.
- done  out  1  one-cycle pulse when a command completes.
- div_zero  out  1  one-cycle pulse when a DIV with rt_val==0 is rejected.
- hi_out  out  WIDTH  architectural HI.
- lo_out  out  WIDTH  architectural LO.
- mul_start  out  1  start to multiplier.
- mul_a, mul_b  out  WIDTH  latched operands to multiplier.
- mul_hi, mul_lo  in  WIDTH  multiplier result.
- mul_ready  in  1  multiplier completion pulse.
- div_start  out  1  start to divider.
- div_a, div_b  out  WIDTH  latched operands to divider.
- div_q, div_r  in  WIDTH  divider quotient / remainder.
- div_ready  in  1  divider completion pulse.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0, including hi_out, lo_out and the operand/start outputs.
- States: IDLE, ISSUE, WAIT, COMMIT (COMMIT may be merged into the WAIT exit edge).
- IDLE + op_valid, op_code MULT:
  - latch rs_val/rt_val into operand regs;
  - record sel=MUL;
  - go to ISSUE.
- IDLE + op_valid, op_code DIV:
  - if rt_val==0: stay IDLE, no engine start, HI/LO unchanged; pulse div_zero and done on the next cycle;
  - otherwise proceed as for MULT with sel=DIV.
- IDLE + op_valid, MTHI/MTLO:
  - write rs_val into HI or LO at that edge;
  - done pulses next cycle;
  - busy never rises.
- ISSUE: the selected start (mul_start or div_start) is high for exactly this one cycle; the other start stays 0. Next state is WAIT.
- WAIT: wait for the selected engine's ready.
  - ready from the non-selected engine is ignored.
  - On the edge where the selected ready is sampled high:
    - MUL: HI<=mul_hi, LO<=mul_lo;
    - DIV: LO<=div_q, HI<=div_r;
    - state goes to IDLE and done<=1 for one cycle.
- busy is high exactly when state is ISSUE or WAIT.
- mul_a/mul_b/div_a/div_b stay stable from ISSUE until the ready commit.
- op_valid outside IDLE is ignored; no queueing. The control unit must hold op_valid while busy.
- Latency with the 32-iteration multiplier, counting from the accepting edge T0:
  - ISSUE occupies T0..T1;
  - the engine samples start at T1;
  - mul_ready is set at T34;
  - commit occurs at T35;
  - done is high in the cycle after T35.
- A new command may be accepted in the same cycle done is high.
- Reset mid-operation aborts: HI/LO are cleared and any later ready pulse is ignored, since the state is IDLE.

Optional Feature:
- Macro: MULDIV_TIMEOUT_EN.
- With the macro defined:
  - a cycle counter clears on entering WAIT and increments each WAIT cycle;
  - if it reaches TIMEOUT without the selected ready, the FSM returns to IDLE, HI/LO are unchanged, and done plus an extra output port timeout (1 bit, one-cycle pulse) are asserted.
- Without the macro: there is no counter and no timeout port, and WAIT is held indefinitely.

Test Plan:
- Reset with rst_n=0 mid-WAIT -> busy=0, hi_out=lo_out=0 immediately; the following mul_ready pulse causes no change.
- MULT rs=7, rt=6 with the real multiplier -> mul_start high for exactly 1 cycle; busy high until commit; done high in the cycle after the 35th edge; hi_out=0, lo_out=42.
- MULT rs=0xFFFFFFFF (-1), rt=2 -> hi_out=0xFFFFFFFF, lo_out=0xFFFFFFFE.
- DIV rs=100, rt=7 with a stub divider returning ready after 5 cycles -> lo_out=14, hi_out=2; a stray mul_ready injected during WAIT is ignored.
- DIV rt=0 with HI=0x11, LO=0x22 preloaded via MTHI/MTLO -> div_zero and done pulse 1 cycle each; div_start stays 0; HI/LO unchanged.
- With MULDIV_TIMEOUT_EN and TIMEOUT=8, MULT with mul_ready tied 0 -> timeout and done pulse 8 cycles after WAIT entry; busy drops; HI/LO unchanged.
